clock_ratio_monitor: RTL and testbench

- Receive-side companion to the team's clock divider; runs in the fast clk_in domain and watches a slow divided clock or strobe (sig_in).
- Measures the sig_in period in clk_in cycles and checks it against the expected CLK_IN/CLK_OUT ratio.
- Reports lock status and a missing-clock timeout.
- Used for divided-clock health checks and bring-up diagnostics.

---
 rtl/clock_ratio_monitor_if.sv | 28 ++
 rtl/clock_ratio_monitor.sv | 151 +++++++++++++++
 tb/tb_clock_ratio_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/clock_ratio_monitor_if.sv
// Signal bundle between a slow-clock source and the clock ratio monitor.
// The master drives the monitored clock; the slave (the monitor) reports
// the measured period, lock status and missing-clock timeout.
interface clock_ratio_monitor_if #(
    parameter int CNT_W = 5
);
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output sig_in,
        input  period,
        input  period_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  sig_in,
        output period,
        output period_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/clock_ratio_monitor.sv
// Clock ratio monitor: measures the period of a slow, asynchronous clock
// (sig_in) in clk_in cycles, compares it with the expected CLK_IN/CLK_OUT
// ratio, and reports lock and a missing-clock timeout. All outputs are
// registered; sig_in only reaches logic through the synchronizer chain.
module clock_ratio_monitor #(
    parameter int CLK_IN      = 100,
    parameter int CLK_OUT     = 10,
    parameter int TOLERANCE   = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    clock_ratio_monitor_if.slave  bus
);

    localparam int EXP     = CLK_IN / CLK_OUT;
    localparam int MAX     = 2 * EXP;
    localparam int CNT_W   = $clog2(MAX + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   TOL_LO   = CNT_W'(EXP - TOLERANCE);
    localparam logic [CNT_W-1:0]   TOL_HI   = CNT_W'(EXP + TOLERANCE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX - 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                 prev_reg;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [MATCH_W-1:0]   match_reg, match_next;
    logic [CNT_W-1:0]     period_reg, period_next;
    logic                 period_valid_reg, period_valid_next;
    logic                 locked_reg, locked_next;
    logic                 timeout_reg, timeout_next;

    logic                 sync_out;
    logic                 sig_rise;
    logic [CNT_W-1:0]     n_val;
    logic                 in_tol;
    logic [MATCH_W-1:0]   match_inc;

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign sig_rise = sync_out & ~prev_reg;

    // Synchronize sig_in into clk_in and keep the previous sample for edge detection
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.sig_in};
            prev_reg <= sync_out;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            match_reg        <= '0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            locked_reg       <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            match_reg        <= match_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            locked_reg       <= locked_next;
            timeout_reg      <= timeout_next;
        end
    end

    // Next-state logic: measure on each detected rising edge, time out when none arrives
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        match_next        = match_reg;
        period_next       = period_reg;
        period_valid_next = 1'b0;
        locked_next       = locked_reg;
        timeout_next      = 1'b0;

        // cnt never exceeds MAX-1, so cnt+1 always fits in CNT_W
        n_val     = cnt_reg + CNT_W'(1);
        in_tol    = (n_val >= TOL_LO) && (n_val <= TOL_HI);
        match_inc = (match_reg == MATCH_FULL) ? match_reg : match_reg + MATCH_W'(1);

        case (state_reg)
            IDLE: begin
                // A single edge only starts the measurement; it defines no period yet
                cnt_next = '0;
                if (sig_rise) begin
                    state_next = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (sig_rise) begin
                    // An edge wins over a coincident timeout (period = MAX is reported)
                    cnt_next          = '0;
                    period_next       = n_val;
                    period_valid_next = 1'b1;
                    if (in_tol) begin
                        match_next = match_inc;
                        if (match_inc == MATCH_FULL) begin
                            locked_next = 1'b1;
                            state_next  = LOCKED;
                        end else begin
                            state_next  = MEASURE;
                        end
                    end else begin
                        match_next  = '0;
                        locked_next = 1'b0;
                        state_next  = MEASURE;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    // Clock missing for MAX cycles: drop lock and wait for a fresh edge
                    timeout_next = 1'b1;
                    locked_next  = 1'b0;
                    match_next   = '0;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                cnt_next    = '0;
                match_next  = '0;
                locked_next = 1'b0;
            end
        endcase
    end

    assign bus.period       = period_reg;
    assign bus.period_valid = period_valid_reg;
    assign bus.locked       = locked_reg;
    assign bus.timeout      = timeout_reg;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed, table-driven bench for clock_ratio_monitor (EXP=10, MAX=20).
// Each table row drives one sig_in period (high hi cycles, low lo cycles)
// starting with a rising edge, and states what the monitor must report
// inside that window: the strobe for the period that ended at this edge,
// the held period, the lock state and any timeout.
module tb_clock_ratio_monitor;

    localparam int NV = 33;
    // Strobe sample index inside a window: 2 sync flops + edge register
    localparam int PV_K = 2;
    // Timeout sample index: strobe index plus MAX cycles
    localparam int TO_K = 22;

    typedef struct {
        int hi;
        int lo;
        bit rst_before;
        int exp_pv;
        int exp_period;
        int exp_lock_pv;
        int exp_lock_end;
        int exp_to;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t vecs [NV];

    clock_ratio_monitor_if #(.CNT_W(5)) bus ();

    clock_ratio_monitor #(
        .CLK_IN      (100),
        .CLK_OUT     (10),
        .TOLERANCE   (1),
        .LOCK_COUNT  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " period"},       int'(bus.period),       0);
        check({tag, " period_valid"}, int'(bus.period_valid), 0);
        check({tag, " locked"},       int'(bus.locked),       0);
        check({tag, " timeout"},      int'(bus.timeout),      0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int pv_cnt, to_cnt, both_cnt, pv_k, to_k, per_pv, lock_pv;
        pv_cnt = 0; to_cnt = 0; both_cnt = 0;
        pv_k = -1; to_k = -1; per_pv = -1; lock_pv = -1;
        if (v.rst_before) begin
            rst = 1'b1;
            @(posedge clk_in);
            @(negedge clk_in);
            check_all_zero($sformatf("vec%0d mid-reset", idx));
            rst = 1'b0;
        end
        bus.sig_in = 1'b1;
        for (int k = 0; k < v.hi + v.lo; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (bus.period_valid) begin
                pv_cnt++;
                if (pv_k < 0) pv_k = k;
                per_pv  = int'(bus.period);
                lock_pv = int'(bus.locked);
            end
            if (bus.timeout) begin
                to_cnt++;
                if (to_k < 0) to_k = k;
            end
            if (bus.period_valid && bus.timeout) both_cnt++;
            if (k == v.hi - 1) bus.sig_in = 1'b0;
        end
        check($sformatf("vec%0d strobe count", idx),  pv_cnt, v.exp_pv);
        check($sformatf("vec%0d timeout count", idx), to_cnt, v.exp_to);
        check($sformatf("vec%0d strobe+timeout overlap", idx), both_cnt, 0);
        check($sformatf("vec%0d period held", idx), int'(bus.period), v.exp_period);
        check($sformatf("vec%0d locked at end", idx), int'(bus.locked), v.exp_lock_end);
        if (v.exp_pv != 0) begin
            check($sformatf("vec%0d strobe position", idx), pv_k, PV_K);
            check($sformatf("vec%0d period at strobe", idx), per_pv, v.exp_period);
            check($sformatf("vec%0d locked at strobe", idx), lock_pv, v.exp_lock_pv);
        end
        if (v.exp_to != 0) begin
            check($sformatf("vec%0d timeout position", idx), to_k, TO_K);
        end
        $display("vec %0d: len=%0d strobes=%0d period=%0d locked=%0d timeouts=%0d",
                 idx, v.hi + v.lo, pv_cnt, int'(bus.period), int'(bus.locked), to_cnt);
    endtask

    initial begin
        //            hi  lo rst pv per lpv lend to
        // Lock from cold: first edge silent, lock on the 4th strobe
        vecs[0]  = '{5,  5, 1'b0, 0,  0, 0, 0, 0};
        vecs[1]  = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[2]  = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[3]  = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[4]  = '{5,  5, 1'b0, 1, 10, 1, 1, 0};
        // Tolerance: 11 and 9 keep lock, 12 breaks it, four 10s relock
        vecs[5]  = '{5,  6, 1'b0, 1, 10, 1, 1, 0};
        vecs[6]  = '{5,  4, 1'b0, 1, 11, 1, 1, 0};
        vecs[7]  = '{6,  6, 1'b0, 1,  9, 1, 1, 0};
        vecs[8]  = '{5,  5, 1'b0, 1, 12, 0, 0, 0};
        vecs[9]  = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[10] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[11] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[12] = '{5,  5, 1'b0, 1, 10, 1, 1, 0};
        // Timeout: clock stops, one timeout 20 cycles after the last edge, period kept
        vecs[13] = '{5, 30, 1'b0, 1, 10, 1, 0, 1};
        vecs[14] = '{5,  5, 1'b0, 0, 10, 0, 0, 0};
        vecs[15] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[16] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[17] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[18] = '{5,  5, 1'b0, 1, 10, 1, 1, 0};
        // Boundary: edges exactly MAX apart report period 20, never time out
        vecs[19] = '{5, 15, 1'b0, 1, 10, 1, 1, 0};
        vecs[20] = '{5, 15, 1'b0, 1, 20, 0, 0, 0};
        vecs[21] = '{5, 15, 1'b0, 1, 20, 0, 0, 0};
        vecs[22] = '{5,  5, 1'b0, 1, 20, 0, 0, 0};
        vecs[23] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[24] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[25] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[26] = '{5,  5, 1'b0, 1, 10, 1, 1, 0};
        // Reset while locked: everything cleared, relock needs 1 edge + 4 periods
        vecs[27] = '{5,  5, 1'b1, 0,  0, 0, 0, 0};
        vecs[28] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[29] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[30] = '{5,  5, 1'b0, 1, 10, 0, 0, 0};
        vecs[31] = '{5,  5, 1'b0, 1, 10, 1, 1, 0};
        vecs[32] = '{5,  5, 1'b0, 1, 10, 1, 1, 0};

        // Reset held 3 cycles while sig_in toggles: outputs stay cleared
        bus.sig_in = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check_all_zero($sformatf("reset cycle %0d", i));
            bus.sig_in = ~bus.sig_in;
        end
        bus.sig_in = 1'b0;
        rst = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check_all_zero("after reset release");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
        end

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
